pdm_modulator: RTL and testbench

Delta-sigma modulator that converts a stream of signed PCM samples into a 1-bit PDM stream (M_DATA) with its bit clock (M_CLK). It is the transmit end of the PDM microphone interface that TOP_FURRY receives. It replaces hand-coded M_DATA bit sequences in loopback simulation. It can also drive an external PDM input (audio-out or second board) from the spectrum-analyzer datapath.

---
 rtl/pdm_pkg.sv | 31 +++
 rtl/pdm_modulator_if.sv | 15 +
 rtl/pdm_clk_gen.sv | 30 +++
 rtl/pdm_modulator.sv | 115 +++++++++++
 tb/tb_pdm_modulator.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM transmit path: default sample width, sample and
// accumulator types, full-scale helper and a saturating adder.
package pdm_pkg;

    localparam int PDM_SAMPLE_W = 16;

    typedef logic signed [PDM_SAMPLE_W-1:0] sample_t;
    typedef logic signed [PDM_SAMPLE_W+3:0] acc_t;

    // Full scale of a w-bit two's complement value, 2^(w-1).
    function automatic longint fs_of(input int w);
        fs_of = longint'(1) << (w - 1);
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint sum;
        longint hi;
        longint lo;
        sum = a + b;
        hi  = fs_of(w) - 1;
        lo  = -fs_of(w);
        if (sum > hi) begin
            sat_add = hi;
        end else if (sum < lo) begin
            sat_add = lo;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/pdm_modulator_if.sv
// PCM sample stream into the PDM modulator.
interface pdm_modulator_if
    import pdm_pkg::*;
#(
    parameter int SAMPLE_W = PDM_SAMPLE_W
);
    // A sample transfers on a rising clk edge where sample_valid && sample_ready;
    // the producer holds sample_in stable while sample_valid is high and unaccepted.
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_valid;
    logic                       sample_ready;

    modport master (output sample_in, output sample_valid, input sample_ready);
    modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/pdm_clk_gen.sv
// PDM bit clock generator: half-period counter, registered M_CLK, and a strobe
// marking the cycle whose closing edge drives M_CLK from 1 to 0.
module pdm_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset,
    output logic m_clk,
    output logic fe
);
    localparam int HC_W = $clog2(CLK_DIV);

    logic [HC_W-1:0] hc;
    logic            wrap;

    assign wrap = (hc == HC_W'(CLK_DIV - 1));
    assign fe   = wrap && m_clk;

    always_ff @(posedge clk) begin
        if (reset) begin
            hc    <= '0;
            m_clk <= 1'b0;
        end else if (wrap) begin
            hc    <= '0;
            m_clk <= !m_clk;
        end else begin
            hc <= hc + HC_W'(1);
        end
    end
endmodule

// File: rtl/pdm_modulator.sv
// Delta-sigma PCM to 1-bit PDM modulator with a one-deep sample holding register.
// Define PDM_MOD_SECOND_ORDER_EN for a second-order loop; default is first order.
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int SAMPLE_W = PDM_SAMPLE_W,
    parameter int CLK_DIV  = 25,
    parameter int OSR      = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    pdm_modulator_if.slave         pcm,
    output logic                   M_CLK,
    output logic                   M_DATA,
    output logic                   underflow
);
    localparam int BC_W = $clog2(OSR);

    logic                       fe;
    logic signed [SAMPLE_W-1:0] x;
    logic signed [SAMPLE_W-1:0] nxt;
    logic                       nxt_full;
    logic [BC_W-1:0]            bc;
    logic                       ready;
    logic                       accept;
    logic                       load_slot;
    logic                       bit_next;

    pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk   (clk),
        .reset (reset),
        .m_clk (M_CLK),
        .fe    (fe)
    );

    assign ready            = !nxt_full && !reset;
    assign pcm.sample_ready = ready;
    assign accept           = pcm.sample_valid && ready;
    assign load_slot        = fe && (bc == BC_W'(OSR - 1));

`ifdef PDM_MOD_SECOND_ORDER_EN
    localparam int     ACC_W = SAMPLE_W + 4;
    localparam longint FS_L  = fs_of(SAMPLE_W);

    logic signed [ACC_W-1:0] acc1;
    logic signed [ACC_W-1:0] acc2;
    logic signed [ACC_W-1:0] e1;
    logic signed [ACC_W-1:0] e2;
    longint                  fb;

    always_comb begin
        fb       = M_DATA ? FS_L : -FS_L;
        e1       = ACC_W'(sat_add(sat_add(longint'(acc1), longint'(x), ACC_W), -fb, ACC_W));
        e2       = ACC_W'(sat_add(sat_add(longint'(acc2), longint'(e1), ACC_W), -fb, ACC_W));
        bit_next = !e2[ACC_W-1];
    end
`else
    localparam int ACC_W = SAMPLE_W + 2;
    localparam logic signed [ACC_W-1:0] FS_A = ACC_W'(fs_of(SAMPLE_W));

    // First-order state stays within [-2FS, 2FS), so this width never overflows.
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] e;
    logic signed [ACC_W-1:0] fb;

    always_comb begin
        fb       = M_DATA ? FS_A : -FS_A;
        e        = acc + {{2{x[SAMPLE_W-1]}}, x} - fb;
        bit_next = !e[ACC_W-1];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            x         <= '0;
            nxt       <= '0;
            nxt_full  <= 1'b0;
            bc        <= '0;
            M_DATA    <= 1'b0;
            underflow <= 1'b0;
`ifdef PDM_MOD_SECOND_ORDER_EN
            acc1      <= '0;
            acc2      <= '0;
`else
            acc       <= '0;
`endif
        end else begin
            underflow <= 1'b0;
            // The load-slot bit itself still uses the old x; the new x applies from the next fe.
            if (load_slot) begin
                if (nxt_full) begin
                    x        <= nxt;
                    nxt_full <= 1'b0;
                end else if (accept) begin
                    x <= pcm.sample_in;
                end else begin
                    underflow <= 1'b1;
                end
            end else if (accept) begin
                nxt      <= pcm.sample_in;
                nxt_full <= 1'b1;
            end
            if (fe) begin
                bc     <= bc + BC_W'(1);
                M_DATA <= bit_next;
`ifdef PDM_MOD_SECOND_ORDER_EN
                acc1   <= e1;
                acc2   <= e2;
`else
                acc    <= e;
`endif
            end
        end
    end
endmodule

// File: tb/tb_pdm_modulator.sv
// Bench for pdm_modulator: bit-exact comparison of the PDM stream against a loop
// model fed by a per-period sample plan, plus density, underflow, bypass and reset checks.
module tb_pdm_modulator;
    import pdm_pkg::*;

    localparam int     SAMPLE_W = 16;
    localparam int     CLK_DIV  = 2;
    localparam int     OSR      = 16;
    localparam int     MAX_P    = 24;
    localparam longint FS       = longint'(1) << (SAMPLE_W - 1);
    localparam int     M_SKIP   = 0;
    localparam int     M_MID    = 1;
    localparam int     M_SLOT   = 2;
`ifdef PDM_MOD_SECOND_ORDER_EN
    localparam int TOL    = 2;
    localparam int N_DENS = 3;
`else
    localparam int TOL    = 1;
    localparam int N_DENS = 4;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic M_CLK;
    logic M_DATA;
    logic underflow;

    pdm_modulator_if #(.SAMPLE_W(SAMPLE_W)) sif ();

    pdm_modulator #(.SAMPLE_W(SAMPLE_W), .CLK_DIV(CLK_DIV), .OSR(OSR)) dut (
        .clk       (clk),
        .reset     (reset),
        .pcm       (sif),
        .M_CLK     (M_CLK),
        .M_DATA    (M_DATA),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Monitor: bits are captured on M_CLK falling transitions, as M_DATA updates then.
    int       nbits = 0;
    int       n_win = 0;
    bit       collect = 1'b0;
    bit       prev_mclk = 1'b0;
    logic [0:0] got_q[$];
    logic [0:0] exp_q[$];
    int       uf_q[$];

    always @(negedge clk) begin
        if (reset) begin
            nbits     = 0;
            prev_mclk = 1'b0;
        end else begin
            if (prev_mclk && !M_CLK) begin
                if (collect && nbits < n_win) got_q.push_back(M_DATA);
                nbits++;
            end
            if (underflow && collect && (nbits - 1) < n_win) uf_q.push_back(nbits - 1);
            prev_mclk = M_CLK;
        end
    end

    int      plan_mode[MAX_P+1];
    sample_t plan_val[MAX_P+1];
    longint  xs_m[MAX_P+1];

    task automatic wait_bits(input int target, input bit need_high);
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (nbits >= target && (!need_high || M_CLK)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sif.sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mclk", M_CLK, 0);
        check("rst_mdata", M_DATA, 0);
        check("rst_uf", underflow, 0);
        check("rst_ready", sif.sample_ready, 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", sif.sample_ready, 1);
    endtask

    // Reference: the loop equations applied bit by bit to the x each period should hold.
    task automatic build_expected(input int n);
        longint acc1 = 0;
        longint acc2 = 0;
        longint fb;
        longint e1;
        longint e2;
        bit     b = 1'b0;
        longint lim = FS << 4;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            fb = b ? FS : -FS;
`ifdef PDM_MOD_SECOND_ORDER_EN
            e1 = acc1 + xs_m[k / OSR] - fb;
            if (e1 > lim - 1) e1 = lim - 1;
            if (e1 < -lim) e1 = -lim;
            e2 = acc2 + e1 - fb;
            if (e2 > lim - 1) e2 = lim - 1;
            if (e2 < -lim) e2 = -lim;
            acc1 = e1;
            acc2 = e2;
            b = (e2 >= 0);
`else
            e1 = acc1 + xs_m[k / OSR] - fb;
            acc1 = e1;
            b = (e1 >= 0);
`endif
            exp_q.push_back(b);
        end
    endtask

    task automatic run_plan(input string name, input int p);
        int exp_uf[$];
        int mism = 0;
        n_win = p * OSR;
        got_q.delete();
        uf_q.delete();
        collect = 1'b1;
        for (int j = 1; j <= p; j++) begin
            if (plan_mode[j] == M_MID) begin
                wait_bits((j - 1) * OSR + OSR / 2, 1'b0);
                sif.sample_in = plan_val[j];
                sif.sample_valid = 1'b1;
                check({name, "_ready_mid"}, sif.sample_ready, 1);
                @(posedge clk); #1;
                sif.sample_valid = 1'b0;
                check({name, "_ready_drop"}, sif.sample_ready, 0);
            end else if (plan_mode[j] == M_SLOT) begin
                wait_bits(j * OSR - 1, 1'b1);
                repeat (CLK_DIV - 1) @(posedge clk);
                #1;
                sif.sample_in = plan_val[j];
                sif.sample_valid = 1'b1;
                check({name, "_ready_slot"}, sif.sample_ready, 1);
                @(posedge clk); #1;
                sif.sample_valid = 1'b0;
                check({name, "_slot_ready_hold"}, sif.sample_ready, 1);
                check({name, "_slot_no_uf"}, underflow, 0);
            end
        end
        wait_bits(n_win, 1'b0);
        collect = 1'b0;
        xs_m[0] = 0;
        for (int j = 1; j <= p; j++) begin
            if (plan_mode[j] == M_SKIP) begin
                xs_m[j] = xs_m[j-1];
                exp_uf.push_back(j * OSR - 1);
            end else begin
                xs_m[j] = longint'(plan_val[j]);
            end
        end
        build_expected(n_win);
        check({name, "_nbits"}, got_q.size(), n_win);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) mism++;
        check({name, "_bit_mismatches"}, mism, 0);
        check({name, "_uf_count"}, uf_q.size(), exp_uf.size());
        for (int i = 0; i < uf_q.size() && i < exp_uf.size(); i++)
            check({name, "_uf_index"}, uf_q[i], exp_uf[i]);
    endtask

    task automatic density(input string name, input sample_t v);
        int     ones = 0;
        longint ideal;
        longint dev;
        for (int i = OSR; i < OSR + 256 && i < got_q.size(); i++) ones += int'(got_q[i]);
        ideal = (256 * (longint'(v) + FS)) / (2 * FS);
        dev = longint'(ones) - ideal;
        check($sformatf("%s_ones_%0d_vs_%0d", name, ones, ideal), (dev <= TOL && dev >= -TOL), 1);
    endtask

    sample_t dens_vals[4];

    initial begin
        sif.sample_valid = 1'b0;
        sif.sample_in = '0;
        dens_vals = '{16'h0000, 16'h4000, 16'hC000, 16'h8000};

        // Idle clocking right after reset.
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            check("idle_mclk", M_CLK, (n / CLK_DIV) % 2);
            if (n < 2 * CLK_DIV) check("idle_mdata", M_DATA, 0);
        end

        for (int d = 0; d < N_DENS; d++) begin
            do_reset();
            for (int j = 1; j <= 17; j++) begin
                plan_mode[j] = M_MID;
                plan_val[j] = dens_vals[d];
            end
            run_plan($sformatf("dens%0d", d), 17);
            density($sformatf("dens%0d", d), dens_vals[d]);
        end

        // One sample then starvation: x must hold and underflow fire every slot after.
        do_reset();
        plan_mode[1] = M_MID;
        plan_val[1] = 16'h3000;
        for (int j = 2; j <= 6; j++) plan_mode[j] = M_SKIP;
        run_plan("starve", 6);

        // Samples offered exactly in the load-slot cycle go straight into x.
        do_reset();
        for (int j = 1; j <= 6; j++) begin
            plan_mode[j] = (j == 4) ? M_SKIP : M_SLOT;
            plan_val[j] = sample_t'(j * 4000 - 12000);
        end
        run_plan("bypass", 6);

        // Reset with a sample pending: the pending sample must be discarded.
        do_reset();
        wait_bits(2, 1'b1);
        sif.sample_in = 16'h5000;
        sif.sample_valid = 1'b1;
        @(posedge clk); #1;
        sif.sample_valid = 1'b0;
        check("pend_ready_low", sif.sample_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_mclk", M_CLK, 0);
        check("midrst_mdata", M_DATA, 0);
        check("midrst_uf", underflow, 0);
        check("midrst_ready", sif.sample_ready, 0);
        reset = 1'b0;
        #1;
        check("midrst_ready_after", sif.sample_ready, 1);
        plan_mode[1] = M_SKIP;
        for (int j = 2; j <= 4; j++) begin
            plan_mode[j] = M_MID;
            plan_val[j] = sample_t'(j * 3000);
        end
        run_plan("after_rst", 4);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int j = 1; j <= 8; j++) begin
                plan_mode[j] = int'($urandom_range(0, 2));
`ifdef PDM_MOD_SECOND_ORDER_EN
                plan_val[j] = sample_t'(int'($urandom_range(0, 49152)) - 24576);
`else
                plan_val[j] = sample_t'($urandom_range(0, 65535));
`endif
            end
            run_plan($sformatf("rand%0d", r), 8);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
